// File: rtl/regfile_32x32_wr_pkg.sv
// Shared constants for the 32x32 register file: default widths, depth and
// the index of the hardwired-zero register.
package regfile_32x32_wr_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_COUNT  = 1 << ADDR_W_DEF;
    localparam int REG_ZERO   = 0;

    // True when register index idx must read as a constant zero.
    function automatic bit is_zero_reg(input int idx, input bit zero_r0);
        return zero_r0 && (idx == REG_ZERO);
    endfunction

endpackage : regfile_32x32_wr_pkg

// File: rtl/regfile_32x32_wr_dec.sv
// Write-address decoder: one-hot register select, all zeros when disabled.
module regfile_32x32_wr_dec
    import regfile_32x32_wr_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     en_i,
    input  logic [ADDR_W-1:0]        a_i,
    output logic [(1<<ADDR_W)-1:0]   y_o
);

    // Raise exactly one select line for the addressed register when enabled.
    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o[a_i] = 1'b1;
        end
    end

endmodule : regfile_32x32_wr_dec

// File: rtl/regfile_32x32_wr.sv
// 32-entry register file: decoded single write port, two asynchronous read
// ports, no write-to-read bypass. Register 0 optionally hardwired to zero.
module regfile_32x32_wr
    import regfile_32x32_wr_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]        load_en;
    logic [DEPTH*DATA_W-1:0] regs_flat;

    regfile_32x32_wr_dec #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .en_i (we_i),
        .a_i  (wa_i),
        .y_o  (load_en)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        if (is_zero_reg(g, ZERO_R0)) begin : g_zero
            // Hardwired zero: no storage, writes to this address vanish.
            assign regs_flat[g*DATA_W +: DATA_W] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] data_q;
            logic [DATA_W-1:0] data_d;

            assign data_d = load_en[g] ? wd_i : data_q;

            // Storage flop with async clear; reset always wins over a write.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign regs_flat[g*DATA_W +: DATA_W] = data_q;
        end
    end

    // Read port 1: 32:1 mux over the stored words.
    always_comb begin
        rd1_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ra1_i == i[ADDR_W-1:0]) begin
                rd1_o = regs_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read port 2: independent copy of the same mux.
    always_comb begin
        rd2_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ra2_i == i[ADDR_W-1:0]) begin
                rd2_o = regs_flat[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule : regfile_32x32_wr

// File: tb/tb_regfile_32x32_wr.sv
// Scoreboard bench for regfile_32x32_wr: stimulus pushes expected read data,
// a negedge monitor pops and compares against RD1/RD2.
module tb_regfile_32x32_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    always #5 clk = ~clk;

    regfile_32x32_wr dut (
        .clk_i (clk),
        .rst_i (rst),
        .we_i  (we),
        .wa_i  (wa),
        .wd_i  (wd),
        .ra1_i (ra1),
        .ra2_i (ra2),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    typedef struct packed {
        logic        port;
        logic [31:0] exp;
        logic [15:0] tag;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model[32];

    exp_t        mon_e;
    logic [31:0] mon_act;

    // Monitor: everything queued since the last edge is checked mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_act = mon_e.port ? rd2 : rd1;
            checks++;
            if (mon_act !== mon_e.exp) begin
                failures++;
                $display("FAIL read tag=%0d port=RD%0d got=%h expected=%h",
                         mon_e.tag, mon_e.port ? 2 : 1, mon_act, mon_e.exp);
            end
        end
    end

    always @(posedge clk) begin
        if (we === 1'b1) begin
            assert (!$isunknown(wa)) else $error("write address unknown while we=1");
        end
    end

    task automatic expect_rd(input logic port, input logic [31:0] exp, input int tag);
        sb.push_back('{port: port, exp: exp, tag: tag[15:0]});
    endtask

    // Advance one edge and apply the architectural effect of that edge.
    task automatic tick();
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        w = (we === 1'b1) && (rst === 1'b0) && (wa != 5'd0);
        a = wa;
        d = wd;
        @(posedge clk);
        #1;
        if (rst === 1'b1) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (w) begin
            model[a] = d;
        end
    endtask

    int          wait_cnt;
    logic [31:0] exp_sweep;

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        tick();
        tick();

        // Reset state
        ra1 = 5'd3; ra2 = 5'd31;
        expect_rd(1'b0, 32'h0, 1);
        expect_rd(1'b1, 32'h0, 2);
        tick();
        rst = 1'b0;
        tick();

        // Preload random data, then assert reset mid-cycle with no edge.
        for (int n = 1; n < 32; n++) begin
            we = 1'b1; wa = n[4:0]; wd = $urandom() | 32'h1;
            tick();
        end
        we = 1'b0;
        ra1 = 5'd9; ra2 = 5'd17;
        expect_rd(1'b0, model[9], 10);
        expect_rd(1'b1, model[17], 11);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        expect_rd(1'b0, 32'h0, 12);
        expect_rd(1'b1, 32'h0, 13);
        // Writes attempted while reset is held must be ignored.
        we = 1'b1; wa = 5'd9; wd = 32'hCAFE_F00D;
        tick();
        expect_rd(1'b0, 32'h0, 14);
        tick();
        rst = 1'b0; we = 1'b0;
        expect_rd(1'b0, 32'h0, 15);
        tick();

        // Sequential fill n -> n+1, then sweep port 1.
        for (int n = 1; n < 32; n++) begin
            we = 1'b1; wa = n[4:0]; wd = n + 1;
            tick();
        end
        we = 1'b0;
        for (int n = 0; n < 32; n++) begin
            ra1 = n[4:0];
            exp_sweep = (n == 0) ? 32'h0 : n + 1;
            expect_rd(1'b0, exp_sweep, 100 + n);
            tick();
        end

        // Write to register 0 is dropped.
        we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; ra1 = 5'd0;
        expect_rd(1'b0, 32'h0, 200);
        tick();
        we = 1'b0;
        expect_rd(1'b0, 32'h0, 201);
        tick();

        // Same-cycle write and read: old value before the edge, new after.
        we = 1'b1; wa = 5'd5; wd = 32'h11;
        tick();
        wd = 32'h22; ra1 = 5'd5;
        expect_rd(1'b0, 32'h11, 210);
        tick();
        we = 1'b0;
        expect_rd(1'b0, 32'h22, 211);
        tick();

        // WE low holds the register across several edges.
        we = 1'b0; wa = 5'd7; wd = 32'hFFFF_FFFF;
        tick(); tick(); tick();
        ra1 = 5'd7;
        expect_rd(1'b0, 32'd8, 220);
        tick();

        // Dual read, same then different addresses.
        ra1 = 5'd25; ra2 = 5'd25;
        expect_rd(1'b0, 32'd26, 230);
        expect_rd(1'b1, 32'd26, 231);
        tick();
        ra2 = 5'd31;
        expect_rd(1'b0, 32'd26, 232);
        expect_rd(1'b1, 32'd32, 233);
        tick();

        // Random traffic against the array model (pre-edge reads, no bypass).
        for (int c = 0; c < 500; c++) begin
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom();
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = 5'($urandom_range(0, 31));
            expect_rd(1'b0, model[ra1], 1000 + c);
            expect_rd(1'b1, model[ra2], 1000 + c);
            tick();
        end
        we = 1'b0;

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_32x32_wr
